// File: rtl/broadcast_unit_pkg.sv
// Shared packet definitions: flit layout, algorithm codes, rank/coordinate helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package broadcast_unit_pkg;

    localparam int FLIT_W  = 82;
    localparam int RANK_W  = 9;
    localparam int COORD_W = 3;

    // Collective algorithm codes carried in the algtype field.
    localparam logic [1:0] ALG_BCAST = 2'b10;

    // Network flit, MSB first: valid at bit 81 down to payload at bits 31:0.
    typedef struct packed {
        logic               valid;      // 81
        logic [COORD_W-1:0] dst_z;      // 80:78
        logic [COORD_W-1:0] dst_y;      // 77:75
        logic [COORD_W-1:0] dst_x;      // 74:72
        logic [RANK_W-1:0]  src;        // 71:63
        logic [RANK_W-1:0]  rank;       // 62:54
        logic [7:0]         context_id; // 53:46
        logic [7:0]         tag;        // 45:38
        logic [1:0]         algtype;    // 37:36
        logic [3:0]         op;         // 35:32
        logic [31:0]        payload;    // 31:0
    } flit_t;

    typedef struct packed {
        logic [COORD_W-1:0] z;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } coord_t;

    // Linear rank is the plain concatenation {z, y, x}.
    function automatic logic [RANK_W-1:0] coord_to_rank(input logic [COORD_W-1:0] z,
                                                        input logic [COORD_W-1:0] y,
                                                        input logic [COORD_W-1:0] x);
        return {z, y, x};
    endfunction

    function automatic coord_t rank_to_coord(input logic [RANK_W-1:0] r);
        return coord_t'(r);
    endfunction

endpackage

// File: rtl/broadcast_unit_lsb_pick.sv
// Lowest-set-bit priority encoder: returns index and one-hot of the lowest request.
// Latency: purely combinational.
// Backpressure: none; outputs are zero when no request bit is set.
module lsb_pick #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic [N-1:0]  onehot_o
);

    // Scan from the top down so the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        idx_o    = '0;
        onehot_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o       = IW'(i);
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/broadcast_unit.sv
// Replicates each source flit to every rank in its mask (self excluded), lowest rank first.
// Latency: first copy valid the cycle after acceptance; one copy per cycle when out_ready is high.
// Backpressure: copies hold on !out_ready; a new source is accepted only alongside the last copy.
module broadcast_unit
    import broadcast_unit_pkg::*;
#(
    parameter logic [2:0] rank_z      = 3'b0,
    parameter logic [2:0] rank_y      = 3'b0,
    parameter logic [2:0] rank_x      = 3'b0,
    parameter int         lg_numprocs = 3,
    localparam int        NumProcs    = 1 << lg_numprocs
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FLIT_W-1:0]   in_packet,
    input  logic [NumProcs-1:0] in_mask,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [FLIT_W-1:0]   out_packet,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                done,
    output logic                busy,
    output logic [15:0]         flits_sent
);

    typedef enum logic {IDLE, SEND} state_e;

    localparam logic [RANK_W-1:0] SelfRank = coord_to_rank(rank_z, rank_y, rank_x);

    state_e                 state_q;
    logic [NumProcs-1:0]    pend_q;
    flit_t                  flit_q;
    logic                   done_q;
    logic [15:0]            sent_q;

    flit_t                  in_flit;
    flit_t                  out_flit;
    logic [NumProcs-1:0]    self_bit;
    logic [NumProcs-1:0]    eff_mask;
    logic [NumProcs-1:0]    pick_oh;
    logic [lg_numprocs-1:0] pick_idx;
    logic                   last_copy;
    logic                   in_xfer;
    logic                   out_xfer;

    assign in_flit = flit_t'(in_packet);

    // One-hot of this node's own rank; all zeros if the rank lies outside the mask.
    always_comb begin
        self_bit = '0;
        for (int i = 0; i < NumProcs; i++) begin
            self_bit[i] = (RANK_W'(i) == SelfRank);
        end
    end

    // An invalid flit carries no destinations; a node never sends to itself.
    assign eff_mask = in_flit.valid ? (in_mask & ~self_bit) : '0;

    lsb_pick #(
        .N  (NumProcs),
        .IW (lg_numprocs)
    ) u_pick (
        .req_i    (pend_q),
        .idx_o    (pick_idx),
        .onehot_o (pick_oh)
    );

    assign last_copy = (state_q == SEND) && (pend_q == pick_oh);
    assign out_valid = (state_q == SEND);
    assign in_ready  = (state_q == IDLE) || (out_ready && last_copy);
    assign out_xfer  = out_valid && out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign busy      = (state_q == SEND);
    assign done      = done_q;
    assign flits_sent = sent_q;

    // Stamp the current destination, own rank and broadcast code onto the stored flit.
    always_comb begin
        out_flit         = flit_q;
        out_flit.valid   = 1'b1;
        {out_flit.dst_z, out_flit.dst_y, out_flit.dst_x} = RANK_W'(pick_idx);
        out_flit.src     = SelfRank;
        out_flit.algtype = ALG_BCAST;
        if (state_q == IDLE) begin
            out_flit = '0;
        end
    end

    assign out_packet = out_flit;

    // Control FSM: load a source, drain its copies, chain the next source with no gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            flit_q  <= '0;
            done_q  <= 1'b0;
            sent_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (out_xfer) begin
                sent_q <= sent_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (in_xfer) begin
                        if (eff_mask != '0) begin
                            state_q <= SEND;
                            pend_q  <= eff_mask;
                            flit_q  <= in_flit;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (out_xfer) begin
                        if (last_copy) begin
                            done_q <= 1'b1;
                            if (in_xfer && eff_mask != '0) begin
                                pend_q <= eff_mask;
                                flit_q <= in_flit;
                            end else begin
                                state_q <= IDLE;
                                pend_q  <= '0;
                            end
                        end else begin
                            pend_q <= pend_q & ~pick_oh;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_broadcast_unit.sv
// Bench for broadcast_unit: directed scenarios plus random traffic against a copy-queue model.
// Latency: model expects first copy the cycle after acceptance.
// Backpressure: out_ready is driven low randomly and in directed stalls.
module tb_broadcast_unit;

    localparam int SELF = 3;
    localparam logic [8:0] SELF9 = 9'd3;

    logic        clk;
    logic        rst;
    logic [81:0] in_packet;
    logic [7:0]  in_mask;
    logic        in_valid;
    logic        in_ready;
    logic [81:0] out_packet;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic        busy;
    logic [15:0] flits_sent;

    int n_chk;
    int n_err;

    // Reference model: queue of copies still owed, plus expected done and counter.
    logic [81:0] mq[$];
    logic        m_done;
    logic [15:0] m_sent;

    broadcast_unit #(
        .rank_z      (3'd0),
        .rank_y      (3'd0),
        .rank_x      (3'd3),
        .lg_numprocs (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_packet  (in_packet),
        .in_mask    (in_mask),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_packet (out_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .done       (done),
        .busy       (busy),
        .flits_sent (flits_sent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [81:0] got, input logic [81:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected copy of source flit s addressed to rank d.
    function automatic logic [81:0] mk(input logic [81:0] s, input int d);
        logic [8:0] dst;
        dst = 9'(d);
        return {1'b1, dst, SELF9, s[62:38], 2'b10, s[35:0]};
    endfunction

    function automatic logic [81:0] rnd_pkt(input logic vbit);
        logic [81:0] p;
        p = {18'($urandom), $urandom, $urandom};
        p[81] = vbit;
        return p;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic v, input logic [81:0] p, input logic [7:0] m, input logic ordy);
        logic exp_rdy;
        logic dn;
        int   ncopies;
        @(negedge clk);
        in_valid  = v;
        in_packet = p;
        in_mask   = m;
        out_ready = ordy;
        #1;
        exp_rdy = (mq.size() == 0) || (ordy && mq.size() == 1);
        chk("in_ready",   82'(in_ready),   82'(exp_rdy));
        chk("out_valid",  82'(out_valid),  82'(mq.size() != 0));
        chk("busy",       82'(busy),       82'(mq.size() != 0));
        chk("done",       82'(done),       82'(m_done));
        chk("flits_sent", 82'(flits_sent), 82'(m_sent));
        if (mq.size() != 0) begin
            chk("out_packet", out_packet, mq[0]);
        end
        dn = 1'b0;
        if (ordy && mq.size() != 0) begin
            void'(mq.pop_front());
            m_sent = m_sent + 16'd1;
            if (mq.size() == 0) dn = 1'b1;
        end
        if (v && exp_rdy) begin
            ncopies = 0;
            for (int i = 0; i < 8; i++) begin
                if (p[81] && m[i] && i != SELF) begin
                    mq.push_back(mk(p, i));
                    ncopies++;
                end
            end
            if (ncopies == 0) dn = 1'b1;
        end
        m_done = dn;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b1);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear without waiting for a clock edge.
    task automatic async_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_out_valid",  82'(out_valid),  82'(0));
        chk("rst_busy",       82'(busy),       82'(0));
        chk("rst_flits_sent", 82'(flits_sent), 82'(0));
        chk("rst_done",       82'(done),       82'(0));
        mq.delete();
        m_done = 1'b0;
        m_sent = '0;
        #5;
        rst = 1'b1;
    endtask

    initial begin
        logic [81:0] p1;
        logic [81:0] p2;
        n_chk     = 0;
        n_err     = 0;
        m_done    = 1'b0;
        m_sent    = '0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_packet = '0;
        in_mask   = '0;
        out_ready = 1'b1;
        #1;
        chk("reset_in_ready",   82'(in_ready),   82'(1));
        chk("reset_out_valid",  82'(out_valid),  82'(0));
        chk("reset_busy",       82'(busy),       82'(0));
        chk("reset_done",       82'(done),       82'(0));
        chk("reset_flits_sent", 82'(flits_sent), 82'(0));
        chk("reset_out_packet", out_packet,      82'(0));
        #11;
        rst = 1'b1;
        idle(2);

        // Four copies to ranks 1,2,4,7 back to back, then done.
        p1 = rnd_pkt(1'b1);
        step(1'b1, p1, 8'b1001_0110, 1'b1);
        idle(5);
        chk("four_copies_sent", 82'(flits_sent), 82'(4));

        // Same source with downstream stalled for three cycles after the first copy.
        p1 = rnd_pkt(1'b1);
        step(1'b1, p1, 8'b1001_0110, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        idle(5);

        // Mask names only this node: dropped, done next cycle.
        step(1'b1, rnd_pkt(1'b1), 8'b0000_1000, 1'b1);
        idle(3);

        // Two sources chained with no gap.
        p1 = rnd_pkt(1'b1);
        p2 = rnd_pkt(1'b1);
        step(1'b1, p1, 8'b0000_0110, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        step(1'b1, p2, 8'b1000_0000, 1'b1);
        idle(4);

        // Reset between second and third copy.
        step(1'b1, rnd_pkt(1'b1), 8'b1110_0000, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        async_reset();
        idle(4);

        // Invalid source flit with full mask is dropped.
        step(1'b1, rnd_pkt(1'b0), 8'hFF, 1'b1);
        idle(3);

        // Random traffic with random backpressure.
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(0, 1)),
                 rnd_pkt(1'($urandom_range(0, 7) != 0)),
                 8'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/broadcast_unit.md
BROADCAST_UNIT -- requirements
Module: broadcast_unit

Interface
REQ-001 Parameter rank_z, default 3'b0, z coordinate of this node.
REQ-002 Parameter rank_y, default 3'b0, y coordinate of this node.
REQ-003 Parameter rank_x, default 3'b0, x coordinate of this node.
REQ-004 Parameter lg_numprocs, default 3, log2 of node count; legal range 1..9; num_procs = 1 << lg_numprocs.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in_packet  input  FlitWidth (82)  source flit: valid 81, dst_z 80-78, dst_y 77-75, dst_x 74-72, src 71-63, rank 62-54, contextId 53-46, tag 45-38, algtype 37-36, op 35-32, payload 31-0.
REQ-008 in_mask  input  num_procs  destination set; bit i set means emit one copy to node rank i.
REQ-009 in_valid  input  1  in_packet/in_mask valid.
REQ-010 in_ready  output  1  unit accepts the input this cycle.
REQ-011 out_packet  output  82  replicated flit.
REQ-012 out_valid  output  1  out_packet valid.
REQ-013 out_ready  input  1  downstream accepts out_packet.
REQ-014 done  output  1  one-cycle pulse when a source flit is fully retired.
REQ-015 busy  output  1  high in SEND state.
REQ-016 flits_sent  output  16  count of accepted output flits, wraps 65535->0.

Function
REQ-017 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 FSM states IDLE, SEND; IDLE->SEND on input transfer with nonzero effective mask; SEND->IDLE on transfer of last flit unless a new input with nonzero effective mask transfers the same cycle.
REQ-019 Effective mask = in_mask with bit {rank_z,rank_y,rank_x} (as linear rank) cleared, and all zeros if in_packet[81]==0.
REQ-020 in_ready = 1 in IDLE; in SEND, in_ready = out_ready && exactly one bit remains in the pending mask.
REQ-021 Input with zero effective mask is consumed and dropped: no output, state stays IDLE, done pulses the following cycle.
REQ-022 Pending copies are emitted lowest rank index first, one per output transfer, pending bit cleared on transfer.
REQ-023 First out_valid asserts the cycle after input transfer; with out_ready held high, throughput is one flit per cycle and back-to-back source flits have no gap.
REQ-024 out_packet fields: valid=1; {dst_z,dst_y,dst_x} = 9-bit zero-extended rank index i; src = {rank_z,rank_y,rank_x}; algtype = 2'b10; rank, contextId, tag, op, payload copied unchanged from stored source flit.
REQ-025 While out_valid && !out_ready, out_packet and out_valid remain stable.
REQ-026 done pulses the cycle after the last copy transfers; flits_sent increments by 1 per output transfer.
REQ-027 out_valid is low in IDLE; in_packet is ignored whenever in_ready is low.

Reset
REQ-028 rst low asynchronously forces IDLE, pending mask 0, stored flit 0, out_valid 0, done 0, busy 0, flits_sent 0, regardless of operation in progress.
REQ-029 Flits pending at reset are discarded; no output transfer occurs in the first cycle after rst deasserts.

Structure
REQ-030 Field positions/widths, FlitWidth, algtype codes (broadcast 2'b10) and rank-to-coordinate function SHALL live in the shared packet package also used by reduce_unit.
REQ-031 One sub-module, lsb_pick: combinational lowest-set-bit priority encoder over num_procs bits, outputting index and one-hot.

Verification
REQ-032 Rank 0, in_mask 8'b1001_0110, out_ready=1 -> dst 1,2,4,7 on four consecutive cycles, src 0, done one cycle after the fourth, flits_sent=4.
REQ-033 Same stimulus, out_ready low cycles 2-4 -> dst 2 held stable three cycles, no flit lost or duplicated.
REQ-034 Rank 3, in_mask 8'b0000_1000 (self only) -> no out_valid, done pulse the cycle after acceptance.
REQ-035 Two sources back-to-back, masks 8'b0000_0110 and 8'b1000_0000 -> dst 1,2,7 on consecutive cycles, in_ready high on the cycle dst 2 transfers.
REQ-036 rst asserted between second and third copy of mask 8'b1110_0000 -> out_valid low immediately, flits_sent=0, no further output.
REQ-037 in_packet[81]=0 with in_mask 8'hFF -> dropped, no output, done pulse.
